// File: rtl/vergister_dump.sv
// vergister_dump: debug read-out sequencer for the core register file.
// On a start pulse it asks the core to freeze (stall_req), waits for
// stall_ack, then reads registers 0..SIZE-1 through rd_index/rd_data and
// streams each {index, value} pair on a valid/ready output port.
//
// Optional build macro VERGISTER_DUMP_CHECKSUM_EN appends one extra beat
// carrying the XOR of all dumped values (out_csum=1, out_last=1).
//
// Stream handshake: a beat transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid is raised, out_index, out_data,
// out_last and out_csum stay stable until that transfer; out_ready while
// out_valid=0 has no effect.
module vergister_dump #(
   parameter int SIZE   = 32,
   parameter int WORD_W = 32,
   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              stall_req,
   input  logic              stall_ack,
   output logic [IDX_W-1:0]  rd_index,
   input  logic [WORD_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              out_csum,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HALT_WAIT = 3'd1,
      S_READ      = 3'd2,
      S_SEND      = 3'd3,
      S_CSUM_SEND = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [IDX_W-1:0] idx;
   logic             hs;

`ifdef VERGISTER_DUMP_CHECKSUM_EN
   logic [WORD_W-1:0] csum;
   logic              out_csum_q;
   assign out_csum = out_csum_q;
`else
   assign out_csum = 1'b0;
`endif

   assign hs        = out_valid && out_ready;
   // Everything outside IDLE is "dump in progress"; the core stays frozen
   // through FINISH so stall_req and busy drop together on return to IDLE.
   assign busy      = (state != S_IDLE);
   assign stall_req = (state != S_IDLE);
   assign done      = (state == S_FINISH);
   // idx is cleared on the way back to IDLE, so the read port parks at 0.
   assign rd_index  = idx;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state selection.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (start)     state_nx = S_HALT_WAIT;
         S_HALT_WAIT: if (stall_ack) state_nx = S_READ;
         S_READ:      if (stall_ack) state_nx = S_SEND;
         S_SEND: begin
            if (hs) begin
               if (idx != LAST_IDX) state_nx = S_READ;
`ifdef VERGISTER_DUMP_CHECKSUM_EN
               else                 state_nx = S_CSUM_SEND;
`else
               else                 state_nx = S_FINISH;
`endif
            end
         end
         S_CSUM_SEND: if (hs) state_nx = S_FINISH;
         S_FINISH:    state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // Index walk, beat capture and checksum accumulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         out_valid  <= 1'b0;
         out_index  <= '0;
         out_data   <= '0;
         out_last   <= 1'b0;
`ifdef VERGISTER_DUMP_CHECKSUM_EN
         csum       <= '0;
         out_csum_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               idx <= '0;
`ifdef VERGISTER_DUMP_CHECKSUM_EN
               if (start) csum <= '0;
`endif
            end
            S_HALT_WAIT: begin
               if (stall_ack) idx <= '0;
            end
            S_READ: begin
               // Sample only while the core confirms it is frozen.
               if (stall_ack) begin
                  out_data  <= rd_data;
                  out_index <= idx;
                  out_valid <= 1'b1;
`ifdef VERGISTER_DUMP_CHECKSUM_EN
                  out_last  <= 1'b0;
                  csum      <= csum ^ rd_data;
`else
                  out_last  <= (idx == LAST_IDX);
`endif
               end
            end
            S_SEND: begin
               if (hs) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
`ifdef VERGISTER_DUMP_CHECKSUM_EN
                  else begin
                     out_valid  <= 1'b1;
                     out_index  <= '0;
                     out_data   <= csum;
                     out_csum_q <= 1'b1;
                     out_last   <= 1'b1;
                  end
`endif
               end
            end
            S_CSUM_SEND: begin
               if (hs) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
`ifdef VERGISTER_DUMP_CHECKSUM_EN
                  out_csum_q <= 1'b0;
`endif
               end
            end
            S_FINISH: begin
               idx <= '0;
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

endmodule
